// File: rtl/handshake_rr_scheduler.sv
// Round-robin scheduler with grant lock sharing one downstream valid/ready channel among NumReq requesters.
// Optional statistics counters (handshakes, stall cycles) are built when HS_SCHED_STATS_EN is defined.
module handshake_rr_scheduler #(
  parameter int NumReq   = 4,
  parameter int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  logic [NumReq-1:0]   req_mask_i,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,
  output logic [IdxWidth-1:0] dst_idx_o,
  output logic                busy_o
`ifdef HS_SCHED_STATS_EN
  ,
  input  logic                stat_clr_i,
  output logic [CntWidth-1:0] stat_hs_cnt_o,
  output logic [CntWidth-1:0] stat_stall_cnt_o
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic [IdxWidth-1:0] idx_q;
  logic [NumReq-1:0]   elig;
  logic                hs;
  logic                arb_en;
  logic                win_found;

  if (NumReq < 1 || CntWidth < 1) begin : g_param_check
    $error("handshake_rr_scheduler: NumReq and CntWidth must both be >= 1");
  end

  assign elig   = req_valid_i & req_mask_i;
  assign hs     = (state_q == LOCKED) && dst_ready_i;
  assign arb_en = (state_q == IDLE) || hs;

  assign dst_valid_o = (state_q == LOCKED);
  assign busy_o      = (state_q == LOCKED);
  assign dst_idx_o   = idx_q;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = hs && (idx_q == IdxWidth'(gi));
  end

  always_comb begin
    state_d = state_q;
    if (arb_en) begin
      state_d = win_found ? LOCKED : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  if (NumReq > 1) begin : g_multi
    localparam logic [IdxWidth:0] NumReqW = (IdxWidth + 1)'(NumReq);

    logic [IdxWidth-1:0] idx_d;
    logic [IdxWidth-1:0] ptr_q;
    logic [IdxWidth-1:0] ptr_d;
    logic [IdxWidth-1:0] win_idx;

    function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                     input logic [IdxWidth:0]   ofs);
      logic [IdxWidth:0] sum;
      sum = {1'b0, base} + ofs;
      if (sum >= NumReqW) begin
        sum = sum - NumReqW;
      end
      return sum[IdxWidth-1:0];
    endfunction

    // Search starts from the post-handshake pointer so the requester just served ranks last.
    always_comb begin
      ptr_d     = hs ? wrap_add(idx_q, (IdxWidth + 1)'(1)) : ptr_q;
      win_found = 1'b0;
      win_idx   = ptr_d;
      for (int k = NumReq - 1; k >= 0; k--) begin
        if (elig[wrap_add(ptr_d, (IdxWidth + 1)'(k))]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(ptr_d, (IdxWidth + 1)'(k));
        end
      end
      idx_d = idx_q;
      if (arb_en && win_found) begin
        idx_d = win_idx;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        idx_q <= '0;
        ptr_q <= '0;
      end else begin
        idx_q <= idx_d;
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_single
    assign win_found = elig[0];
    assign idx_q     = '0;
  end

`ifdef HS_SCHED_STATS_EN
  logic [CntWidth-1:0] hs_cnt_q;
  logic [CntWidth-1:0] hs_cnt_d;
  logic [CntWidth-1:0] stall_cnt_q;
  logic [CntWidth-1:0] stall_cnt_d;

  // Clear wins over a same-cycle increment; both counters wrap naturally.
  always_comb begin
    hs_cnt_d    = hs_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stat_clr_i) begin
      hs_cnt_d    = '0;
      stall_cnt_d = '0;
    end else begin
      if (hs) begin
        hs_cnt_d = hs_cnt_q + CntWidth'(1);
      end
      if ((state_q == LOCKED) && !dst_ready_i) begin
        stall_cnt_d = stall_cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      hs_cnt_q    <= hs_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_hs_cnt_o    = hs_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_handshake_rr_scheduler.sv
// Self-checking bench for handshake_rr_scheduler: directed vector table, hand sequences and a random run
// against a behavioural model. Statistics checks are compiled when HS_SCHED_STATS_EN is defined.
module tb_handshake_rr_scheduler;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [3:0] msk;
  logic       rdy;
  logic       clr;
  logic [3:0] rr;
  logic       dvalid;
  logic [1:0] didx;
  logic       busy;
`ifdef HS_SCHED_STATS_EN
  logic [15:0] hs_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  handshake_rr_scheduler #(.NumReq(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (vld),
    .req_ready_o (rr),
    .req_mask_i  (msk),
    .dst_valid_o (dvalid),
    .dst_ready_i (rdy),
    .dst_idx_o   (didx),
    .busy_o      (busy)
`ifdef HS_SCHED_STATS_EN
    ,
    .stat_clr_i       (clr),
    .stat_hs_cnt_o    (hs_cnt),
    .stat_stall_cnt_o (stall_cnt)
`endif
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] msk;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_idx;
    logic [3:0] exp_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [3:0] m, input logic rd,
                               input logic ev, input logic [1:0] ei, input logic [3:0] er);
    vec_t t;
    t.rst = r; t.vld = v; t.msk = m; t.rdy = rd;
    t.exp_v = ev; t.exp_idx = ei; t.exp_rr = er;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] m, input logic rd,
                       input logic c);
    rst = r; vld = v; msk = m; rdy = rd; clr = c;
    #1;
  endtask

  // Behavioural model: a locked flag, the granted index and the next index with top priority.
  int          m_locked;
  int          m_idx;
  int          m_ptr;
  logic [15:0] m_hs;
  logic [15:0] m_stall;

  task automatic model_reset();
    m_locked = 0; m_idx = 0; m_ptr = 0; m_hs = '0; m_stall = '0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] v, input logic [3:0] m, input logic rd,
                            input logic c);
    int   done;
    logic [3:0] e;
    int   found;
    if (r) begin
      model_reset();
      return;
    end
    done = (m_locked != 0 && rd) ? 1 : 0;
    if (c) begin
      m_hs = '0; m_stall = '0;
    end else begin
      if (done != 0) m_hs = m_hs + 16'd1;
      if (m_locked != 0 && !rd) m_stall = m_stall + 16'd1;
    end
    if (done != 0) m_ptr = (m_idx + 1) % N;
    if (m_locked == 0 || done != 0) begin
      e = v & m;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (found == 0 && e[(m_ptr + k) % N]) begin
          found = 1;
          m_idx = (m_ptr + k) % N;
        end
      end
      m_locked = found;
    end
  endtask

  task automatic check_model(input int n);
    logic [3:0] exp_rr;
    exp_rr = (m_locked != 0 && rdy) ? 4'(1 << m_idx) : 4'h0;
    chk($sformatf("rnd%0d.valid", n), 32'(dvalid), 32'(m_locked != 0));
    chk($sformatf("rnd%0d.idx", n), 32'(didx), 32'(m_idx));
    chk($sformatf("rnd%0d.ready", n), 32'(rr), 32'(exp_rr));
    chk($sformatf("rnd%0d.busy", n), 32'(busy), 32'(m_locked != 0));
`ifdef HS_SCHED_STATS_EN
    chk($sformatf("rnd%0d.hs_cnt", n), 32'(hs_cnt), 32'(m_hs));
    chk($sformatf("rnd%0d.stall_cnt", n), 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  initial begin
    logic       r;
    logic [3:0] v;
    logic [3:0] m;
    logic       rd;
    logic       c;

    // Reset state then ten idle cycles.
    drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 4'h0, 4'hF, n[0], 1'b0);
      chk($sformatf("idle%0d.valid", n), 32'(dvalid), 32'd0);
      chk($sformatf("idle%0d.ready", n), 32'(rr), 32'd0);
      chk($sformatf("idle%0d.idx", n), 32'(didx), 32'd0);
      chk($sformatf("idle%0d.busy", n), 32'(busy), 32'd0);
`ifdef HS_SCHED_STATS_EN
      chk($sformatf("idle%0d.hs_cnt", n), 32'(hs_cnt), 32'd0);
      chk($sformatf("idle%0d.stall_cnt", n), 32'(stall_cnt), 32'd0);
`endif
      @(negedge clk);
    end

    //                 rst   vld   msk   rdy   exp_v idx   rr
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0));
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0));  // fairness 0,1,2,3,0
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8));
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1));
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0));
    vecs.push_back(mkv(1'b0, 4'h5, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0));  // pointer at 1 -> grants 2
    for (int n = 0; n < 5; n++) vecs.push_back(mkv(1'b0, 4'h5, 4'hF, 1'b0, 1'b1, 2'd2, 4'h0));
    vecs.push_back(mkv(1'b0, 4'h5, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4));  // wrap to requester 0
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1));  // valid dropped, still completes
    vecs.push_back(mkv(1'b0, 4'hF, 4'hA, 1'b1, 1'b0, 2'd0, 4'h0));  // mask 1010
    vecs.push_back(mkv(1'b0, 4'hF, 4'hA, 1'b1, 1'b1, 2'd1, 4'h2));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hA, 1'b1, 1'b1, 2'd3, 4'h8));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hA, 1'b1, 1'b1, 2'd1, 4'h2));
    vecs.push_back(mkv(1'b0, 4'hF, 4'h2, 1'b0, 1'b1, 2'd3, 4'h0));  // bit 3 cleared while locked
    vecs.push_back(mkv(1'b0, 4'hF, 4'h2, 1'b1, 1'b1, 2'd3, 4'h8));
    vecs.push_back(mkv(1'b0, 4'hF, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2));
    vecs.push_back(mkv(1'b0, 4'hF, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2));
    vecs.push_back(mkv(1'b1, 4'hF, 4'h2, 1'b0, 1'b1, 2'd1, 4'h0));  // reset while locked on 1
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0));
    vecs.push_back(mkv(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0));  // pointer back at 0
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b0, 1'b1, 2'd0, 4'h0));
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1));
    vecs.push_back(mkv(1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 2'd0, 4'h0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].msk, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d.valid", i), 32'(dvalid), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d.idx", i), 32'(didx), 32'(vecs[i].exp_idx));
      chk($sformatf("vec%0d.ready", i), 32'(rr), 32'(vecs[i].exp_rr));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].exp_v));
      @(negedge clk);
    end

`ifdef HS_SCHED_STATS_EN
    drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h1, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      drive(1'b0, 4'h1, 4'hF, 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int n = 0; n < 6; n++) begin
      drive(1'b0, (n == 5) ? 4'h0 : 4'h1, 4'hF, 1'b1, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 4'h1, 4'hF, 1'b0, 1'b0);
    chk("stats.hs_six", 32'(hs_cnt), 32'd6);
    chk("stats.stall_three", 32'(stall_cnt), 32'd3);
    @(negedge clk);
    drive(1'b0, 4'h1, 4'hF, 1'b1, 1'b1);
    chk("stats.hs_in_clr_cycle", 32'(rr), 32'h1);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'hF, 1'b1, 1'b0);
    chk("stats.clr_hs", 32'(hs_cnt), 32'd0);
    chk("stats.clr_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    drive(1'b0, 4'h0, 4'hF, 1'b0, 1'b0);
    chk("stats.after_clr_hs", 32'(hs_cnt), 32'd1);
    chk("stats.after_clr_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
`endif

    // Randomised run against the behavioural model.
    drive(1'b1, 4'h0, 4'hF, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      v  = 4'($urandom);
      m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      rd = 1'($urandom);
      c  = ($urandom_range(0, 31) == 0);
      drive(r, v, m, rd, c);
      check_model(n);
      model_step(r, v, m, rd, c);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
